// File: rtl/decimal_entry_pkg.sv
// Shared types, range limits and the BCD accumulate step for decimal_entry.
package decimal_entry_pkg;

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, CHECK} state_t;

  localparam int BCD_MAX  = 9;
  localparam int UMAX     = 1023;
  localparam int SMAX_POS = 511;
  localparam int SMAX_NEG = 512;
  localparam int ACC_W    = 14;

  // Sign/format captured on the enter press, held through the conversion.
  typedef struct packed {
    logic neg;
    logic smode;
  } mode_t;

  // acc*10 + d without a multiplier.
  function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + ACC_W'(d);
  endfunction

  function automatic logic [ACC_W-1:0] limit(input mode_t m);
    if (!m.smode) return ACC_W'(UMAX);
    return m.neg ? ACC_W'(SMAX_NEG) : ACC_W'(SMAX_POS);
  endfunction

endpackage

// File: rtl/decimal_entry_if.sv
// Board-side bundle: switches and keys in, converted value and HEX echo out.
interface decimal_entry_if #(parameter int MAX_DIGITS = 4);
  logic [3:0]              digit_in;
  logic                    neg;
  logic                    signed_mode;
  logic                    btn_digit_n;
  logic                    btn_enter_n;
  logic [9:0]              value;
  logic                    valid;
  logic                    err;
  logic [4*MAX_DIGITS-1:0] entry_bcd;
  logic [2:0]              digit_count;
  logic                    busy;

  modport master (
    output digit_in, neg, signed_mode, btn_digit_n, btn_enter_n,
    input  value, valid, err, entry_bcd, digit_count, busy
  );

  modport slave (
    input  digit_in, neg, signed_mode, btn_digit_n, btn_enter_n,
    output value, valid, err, entry_bcd, digit_count, busy
  );
endinterface

// File: rtl/decimal_entry_key_debounce.sv
// Active-low key: 2-FF synchronizer, stability counter, one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          db, db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      db      <= 1'b1;
      db_q    <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync    <= {sync[0], key_n};
      db_q    <= db;
      pressed <= db_q & ~db;
      // Any bounce back to the current level restarts the stability count.
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/decimal_entry.sv
// Keyed BCD entry with serial BCD-to-binary conversion and 10-bit range check.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MAX_DIGITS      = 4
) (
  input logic            clk,
  input logic            rst_n,
  decimal_entry_if.slave bus
);
  localparam int BW = 4 * MAX_DIGITS;

  logic dig_ev, ent_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dig (
    .clk(clk), .rst_n(rst_n), .key_n(bus.btn_digit_n), .pressed(dig_ev)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (
    .clk(clk), .rst_n(rst_n), .key_n(bus.btn_enter_n), .pressed(ent_ev)
  );

  state_t           state;
  mode_t            mode;
  logic [ACC_W-1:0] acc;
  logic [2:0]       idx;
  logic [BW-1:0]    bcd;
  logic [2:0]       cnt;
  logic [9:0]       value;
  logic             valid, err, busy;
  logic [3:0]       cur_dig;
  logic [9:0]       twos;

  // Walk the buffer MSB-first; leading zero nibbles just accumulate zero.
  assign cur_dig = bcd[idx*4 +: 4];
  assign twos    = ~acc[9:0] + 10'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= '0;
      acc   <= '0;
      idx   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      value <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          // Enter takes priority; a digit arriving in the same cycle is dropped.
          if (ent_ev) begin
            mode.neg   <= bus.neg;
            mode.smode <= bus.signed_mode;
            acc        <= '0;
            idx        <= 3'(MAX_DIGITS - 1);
            busy       <= 1'b1;
            state      <= CONVERT;
          end else if (dig_ev && bus.digit_in <= 4'(BCD_MAX) && cnt < 3'(MAX_DIGITS)) begin
            bcd   <= {bcd[BW-5:0], bus.digit_in};
            cnt   <= cnt + 3'd1;
            state <= ENTRY;
          end
        end
        CONVERT: begin
          acc <= mul10_add(acc, cur_dig);
          idx <= idx - 3'd1;
          if (idx == 3'd0) state <= CHECK;
        end
        CHECK: begin
          if (acc <= limit(mode)) begin
            value <= (mode.neg && mode.smode) ? twos : acc[9:0];
            valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          bcd   <= '0;
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.value       = value;
  assign bus.valid       = valid;
  assign bus.err         = err;
  assign bus.entry_bcd   = bcd;
  assign bus.digit_count = cnt;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_decimal_entry.sv
// Directed table-driven bench for decimal_entry with a short debounce window.
module tb_decimal_entry;
  localparam int MD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decimal_entry_if #(.MAX_DIGITS(MD)) bus();

  decimal_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          nd;
    logic [15:0] digs;   // right-justified BCD, typed MSB first
    logic        neg;
    logic        sm;
    logic        ev;     // 1 = expect valid, 0 = expect err
    logic [9:0]  val;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_digit(input logic [3:0] d);
    bus.digit_in    = d;
    bus.btn_digit_n = 1'b0;
    tick(12);
    bus.btn_digit_n = 1'b1;
    tick(12);
  endtask

  // Press enter, wait for busy (cycle E+1), then watch the pulses that follow.
  task automatic commit(input logic n, input logic sm, output int nv, output int ne,
                        output int off, output int nb);
    int t;
    nv = 0; ne = 0; off = -1; nb = 0; t = 0;
    bus.neg = n;
    bus.signed_mode = sm;
    bus.btn_enter_n = 1'b0;
    while (!bus.busy && t < 40) begin
      tick(1);
      t++;
    end
    bus.btn_enter_n = 1'b1;
    chk("busy_seen", 32'(bus.busy), 32'd1);
    if (bus.busy) nb = 1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (bus.busy) nb++;
      if (bus.valid || bus.err) begin
        if (off < 0) off = k;
        nv += int'(bus.valid);
        ne += int'(bus.err);
      end
    end
    tick(12);
  endtask

  initial begin
    int nv, ne, off, nb;
    bus.digit_in = 4'd0;
    bus.neg = 1'b0;
    bus.signed_mode = 1'b0;
    bus.btn_digit_n = 1'b1;
    bus.btn_enter_n = 1'b1;

    tbl[0]  = '{2, 16'h0010, 1'b0, 1'b0, 1'b1, 10'h00A};
    tbl[1]  = '{2, 16'h0010, 1'b1, 1'b1, 1'b1, 10'h3F6};
    tbl[2]  = '{4, 16'h1023, 1'b0, 1'b0, 1'b1, 10'h3FF};
    tbl[3]  = '{4, 16'h1024, 1'b0, 1'b0, 1'b0, 10'h3FF};
    tbl[4]  = '{3, 16'h0512, 1'b1, 1'b1, 1'b1, 10'h200};
    tbl[5]  = '{3, 16'h0512, 1'b0, 1'b1, 1'b0, 10'h200};
    tbl[6]  = '{1, 16'h0000, 1'b1, 1'b1, 1'b1, 10'h000};
    tbl[7]  = '{3, 16'h0511, 1'b0, 1'b1, 1'b1, 10'h1FF};
    tbl[8]  = '{0, 16'h0000, 1'b0, 1'b0, 1'b1, 10'h000};
    tbl[9]  = '{3, 16'h0999, 1'b1, 1'b0, 1'b1, 10'h3E7};
    tbl[10] = '{3, 16'h0513, 1'b1, 1'b1, 1'b0, 10'h3E7};

    tick(3);
    chk("rst_value", 32'(bus.value), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    chk("rst_bcd",   32'(bus.entry_bcd), 32'd0);
    chk("rst_count", 32'(bus.digit_count), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 11; i++) begin
      vec_t v;
      v = tbl[i];
      for (int j = v.nd - 1; j >= 0; j--) press_digit(v.digs[j*4 +: 4]);
      chk($sformatf("v%0d_count", i), 32'(bus.digit_count), 32'(v.nd));
      chk($sformatf("v%0d_bcd", i), 32'(bus.entry_bcd), 32'(v.digs));
      commit(v.neg, v.sm, nv, ne, off, nb);
      chk($sformatf("v%0d_nvalid", i), 32'(nv), v.ev ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_nerr", i), 32'(ne), v.ev ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_pulse_at", i), 32'(off), 32'd5);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(MD + 1));
      chk($sformatf("v%0d_value", i), 32'(bus.value), 32'(v.val));
      chk($sformatf("v%0d_count_clr", i), 32'(bus.digit_count), 32'd0);
      chk($sformatf("v%0d_bcd_clr", i), 32'(bus.entry_bcd), 32'd0);
    end

    // Short glitch must not register as a press.
    bus.digit_in = 4'd5;
    bus.btn_digit_n = 1'b0;
    tick(2);
    bus.btn_digit_n = 1'b1;
    tick(20);
    chk("glitch_count", 32'(bus.digit_count), 32'd0);

    press_digit(4'd12);
    chk("nonbcd_count", 32'(bus.digit_count), 32'd0);

    press_digit(4'd0);
    press_digit(4'd1);
    press_digit(4'd2);
    press_digit(4'd3);
    press_digit(4'd4);
    chk("full_count", 32'(bus.digit_count), 32'd4);
    chk("full_bcd", 32'(bus.entry_bcd), 32'h0123);
    commit(1'b0, 1'b0, nv, ne, off, nb);
    chk("full_nvalid", 32'(nv), 32'd1);
    chk("full_value", 32'(bus.value), 32'h07B);

    // Digit and enter debounce in lockstep, so both events land together.
    press_digit(4'd4);
    press_digit(4'd2);
    bus.digit_in = 4'd7;
    bus.btn_digit_n = 1'b0;
    commit(1'b0, 1'b0, nv, ne, off, nb);
    bus.btn_digit_n = 1'b1;
    tick(12);
    chk("simul_nvalid", 32'(nv), 32'd1);
    chk("simul_value", 32'(bus.value), 32'h02A);
    chk("simul_count", 32'(bus.digit_count), 32'd0);

    // Reset in cycle E+2 kills the conversion.
    begin
      int t, pulses;
      t = 0;
      pulses = 0;
      press_digit(4'd3);
      press_digit(4'd4);
      press_digit(4'd5);
      bus.btn_enter_n = 1'b0;
      while (!bus.busy && t < 40) begin
        tick(1);
        t++;
      end
      bus.btn_enter_n = 1'b1;
      chk("rstmid_busy_seen", 32'(bus.busy), 32'd1);
      tick(1);
      rst_n = 1'b0;
      tick(1);
      chk("rstmid_value", 32'(bus.value), 32'd0);
      chk("rstmid_busy",  32'(bus.busy), 32'd0);
      chk("rstmid_count", 32'(bus.digit_count), 32'd0);
      chk("rstmid_bcd",   32'(bus.entry_bcd), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        tick(1);
        if (bus.valid || bus.err) pulses++;
      end
      chk("rstmid_no_pulse", 32'(pulses), 32'd0);
      press_digit(4'd7);
      commit(1'b0, 1'b0, nv, ne, off, nb);
      chk("rstmid_after_nvalid", 32'(nv), 32'd1);
      chk("rstmid_after_value", 32'(bus.value), 32'h007);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
